// File: rtl/add_pkg.sv
// Shared constants and result record for the shared-adder arbiter.
package add_pkg;
  localparam int NREQ_DEF = 4;
  localparam int DW_DEF   = 15;
  localparam int SW_DEF   = DW_DEF + 1;
  localparam int IDW_DEF  = $clog2(NREQ_DEF);

  // One result leaving the adder: the full-width sum and the requester that owns it.
  typedef struct packed {
    logic [SW_DEF-1:0]  sum;
    logic [IDW_DEF-1:0] id;
  } add_res_t;
endpackage

// File: rtl/add_rr_grant.sv
// Grant selector for the shared adder.
// Default build: round-robin, search starts at ptr and wraps.
// ADD_SHARE_ARB_FIXED_PRIO_EN: lowest index wins, ptr is ignored.
module add_rr_grant
  import add_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  // First requester found in search order gets the grant; gnt is zero when en is low.
  always_comb begin
    int   j;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef ADD_SHARE_ARB_FIXED_PRIO_EN
      j = k;
`else
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
`endif
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = en;
        idx    = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/add_share_arb.sv
// NREQ requesters share one adder through a two-stage pipeline:
// stage 1 registers the granted operand pair, stage 2 holds the sum.
// Macro ADD_SHARE_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module add_share_arb
  import add_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  parameter  int DW   = DW_DEF,
  localparam int SW   = DW + 1,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [SW-1:0]      res_sum,
  output logic [IDW-1:0]     res_id,
  output logic               idle
);

  logic [NREQ-1:0][DW-1:0] a_arr, b_arr;
  logic [DW-1:0]           a1, b1;
  logic [IDW-1:0]          id1;
  logic [2:1]              vld_pipe;   // [1] operand stage, [2] sum stage
  logic [IDW-1:0]          ptr;
  logic [NREQ-1:0]         gnt;
  logic [IDW-1:0]          gidx;
  logic                    ld1, ld2, fire;

  assign a_arr = req_a;
  assign b_arr = req_b;

  // Sum stage takes new data when empty or being drained; operand stage
  // takes new data when empty or when it moves into the sum stage.
  assign ld2       = !vld_pipe[2] || res_ready;
  assign ld1       = !vld_pipe[1] || ld2;
  assign fire      = |gnt;
  assign req_ready = gnt;
  assign res_valid = vld_pipe[2];
  assign idle      = ~|vld_pipe;

  // Gate with rst_n so no requester sees ready while reset is held.
  add_rr_grant #(.NREQ(NREQ)) u_grant (
    .req (req_valid),
    .ptr (ptr),
    .en  (ld1 && rst_n),
    .gnt (gnt),
    .idx (gidx)
  );

`ifdef ADD_SHARE_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  // Pointer moves past the winner only when a transfer actually happens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ptr <= '0;
    else if (fire) ptr <= (gidx == IDW'(NREQ-1)) ? '0 : gidx + IDW'(1);
  end
`endif

  // Two-stage datapath; stalls hold both stages, reset drops anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      a1       <= '0;
      b1       <= '0;
      id1      <= '0;
      res_sum  <= '0;
      res_id   <= '0;
    end else begin
      if (ld2) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          res_sum <= SW'(a1) + SW'(b1);
          res_id  <= id1;
        end
      end
      if (ld1) begin
        vld_pipe[1] <= fire;
        if (fire) begin
          a1  <= a_arr[gidx];
          b1  <= b_arr[gidx];
          id1 <= gidx;
        end
      end
    end
  end

endmodule
